// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Assembles a little-endian byte stream into 32-bit words and
//            writes them to an instruction memory, one strobe per word.
// Revision : 1.0
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 400,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] word_count,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    output logic          byte_ready,
    output logic          we,
    output logic [AW-1:0] waddr,
    output logic [31:0]   wdata,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] loaded_words
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [AW-1:0] c_one = {{(AW-1){1'b0}}, 1'b1};

    logic [2:0]    r_state;
    logic [1:0]    r_idx;
    logic [AW-1:0] r_count;
    logic [AW-1:0] r_loaded;
    logic [AW-1:0] r_waddr;
    logic [31:0]   r_wdata;

    logic          w_count_ok;
    logic [AW-1:0] w_loaded_inc;

    assign w_count_ok   = (word_count != '0) && (32'(word_count) <= DEPTH);
    assign w_loaded_inc = r_loaded + c_one;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= 2'd0;
            r_count  <= '0;
            r_loaded <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_idx    <= 2'd0;
                        r_count  <= word_count;
                        r_loaded <= '0;
                        r_waddr  <= '0;
                        r_wdata  <= '0;
                        r_state  <= w_count_ok ? S_RECV : S_ERR;
                    end
                end
                S_RECV: begin
                    // byte_ready is 1 throughout RECV, so byte_valid alone marks a transfer
                    if (byte_valid) begin
                        r_wdata[{r_idx, 3'b000} +: 8] <= byte_data;
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_waddr <= r_loaded;
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_loaded <= w_loaded_inc;
                    r_state  <= (w_loaded_inc == r_count) ? S_DONE : S_RECV;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All handshake and status outputs are decoded from the state register only
    assign byte_ready   = (r_state == S_RECV);
    assign we           = (r_state == S_WRITE);
    assign busy         = (r_state == S_RECV) || (r_state == S_WRITE);
    assign done         = (r_state == S_DONE);
    assign error        = (r_state == S_ERR);
    assign waddr        = r_waddr;
    assign wdata        = r_wdata;
    assign loaded_words = r_loaded;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 400: number of 32-bit words in the target instruction memory.
REQ-002 SHALL have parameter AW, default 9: width of word address and word count, enough to hold DEPTH.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: request to begin a load session.
REQ-006 SHALL have port word_count, input, AW: number of words to load; sampled when start is accepted.
REQ-007 SHALL have port byte_valid, input, 1: the byte source has a byte on byte_data.
REQ-008 SHALL have port byte_data, input, 8: instruction byte stream, little-endian within each word.
REQ-009 SHALL have port byte_ready, output, 1: the loader accepts a byte this cycle.
REQ-010 SHALL have port we, output, 1: one-cycle write strobe to the instruction memory.
REQ-011 SHALL have port waddr, output, AW: word address for the write; word-indexed, first word at 0.
REQ-012 SHALL have port wdata, output, 32: assembled instruction word.
REQ-013 SHALL have port busy, output, 1: a session is in progress.
REQ-014 SHALL have port done, output, 1: the last session completed successfully.
REQ-015 SHALL have port error, output, 1: the last start was rejected.
REQ-016 SHALL have port loaded_words, output, AW: number of words written in the current or last session.

Function
REQ-017 SHALL implement the states IDLE, RECV, WRITE, DONE and ERR.
REQ-018 SHALL move from IDLE, DONE or ERR on start=1 to RECV when 1 <= word_count <= DEPTH, and otherwise to ERR.
REQ-019 SHALL, on every accepted start, clear loaded_words, the byte index and the word address to 0, and latch word_count.
REQ-020 SHALL ignore start while in RECV or WRITE.
REQ-021 SHALL drive byte_ready=1 only in RECV; a byte transfers only when byte_valid and byte_ready are both 1.
REQ-022 SHALL place transferred byte k (k = 0..3) into wdata[8k+7:8k]; the first byte goes to [7:0].
REQ-023 SHALL increment the 2-bit byte index on each transfer, enter WRITE after the 4th byte, and deassert byte_ready during WRITE.
REQ-024 SHALL in WRITE drive we=1 for exactly one cycle, on the cycle after the 4th-byte transfer, with waddr = loaded_words and the full word on wdata.
REQ-025 SHALL increment loaded_words when leaving WRITE; go to DONE if the new value equals the latched count, and otherwise to RECV.
REQ-026 SHALL hold wdata and waddr stable while we=1; their values when we=0 are don't-care but SHALL NOT be X after reset.
REQ-027 SHALL NOT let waddr exceed DEPTH-1 and SHALL NOT write when the count is rejected.
REQ-028 SHALL stall indefinitely in RECV with no timeout while byte_valid=0, keeping partial-word bytes.
REQ-029 SHALL drive busy=1 in RECV and WRITE; done=1 only in DONE; error=1 only in ERR; the DONE and ERR levels hold until the next start.
REQ-030 SHALL make all outputs registered or decoded from the state register, with no combinational path from byte_valid to byte_ready.

Reset
REQ-031 SHALL, on rst_n=0 at any time, go to IDLE immediately with byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0 and loaded_words=0.
REQ-032 SHALL, on reset during RECV or WRITE, discard the partial word and issue no write; a pending we is cancelled.
REQ-033 SHALL, after rst_n deasserts, wait in IDLE for start.

Verification
REQ-034 SHALL cover: start with word_count=2, bytes 13,00,50,00 then B3,05,00,00 with continuous valid -> we pulses with waddr=0, wdata=00500013, then waddr=1, wdata=000005B3; done=1; loaded_words=2.
REQ-035 SHALL cover: byte_valid toggled randomly with word_count=3 -> exactly 3 we pulses at waddr 0,1,2; no byte lost or duplicated; byte_ready=0 during each WRITE cycle.
REQ-036 SHALL cover: start with word_count=0, then with word_count=401 -> error=1, no we, busy=0; then start with word_count=1 -> clean load, error=0.
REQ-037 SHALL cover: rst_n pulsed low after 2 bytes of word 1 -> all outputs return to reset values at once, no we; a new session then writes from waddr=0.
REQ-038 SHALL cover: start pulsed mid-session -> ignored, the session completes unchanged; start while in DONE -> new session begins, loaded_words=0.
REQ-039 SHALL cover: word_count=400 -> last we at waddr=399, done=1, never waddr=400.
